psw_debounce: RTL and testbench

//  Conditions the 14 raw push-switch inputs before they reach the calculator

---
 rtl/psw_debounce.sv | 114 +++++++++++
 tb/tb_psw_debounce.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/psw_debounce.sv
// rtl/psw_debounce.sv - push-switch synchroniser, tick-sampled debouncer and key encoder
module psw_debounce #(
   parameter int N_SW       = 14,
   parameter int SAMPLE_DIV = 250000,
   parameter int STABLE_CNT = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic            CLK,
   input  logic            RST_X,
   input  logic [N_SW-1:0] PSW,
   output logic [N_SW-1:0] PSW_LEVEL,
   output logic [N_SW-1:0] PSW_PULSE,
   output logic            KEY_VALID,
   output logic [3:0]      KEY_CODE,
   output logic            KEY_MULTI
);

   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam int CNT_W = $clog2(STABLE_CNT) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   // Polarity is normalised before synchronising so that reset value 0 always means released.
   logic [N_SW-1:0] norm;
   assign norm = ACTIVE_LOW ? ~PSW : PSW;

   logic [N_SW-1:0]            sync1_q, sync1_d;
   logic [N_SW-1:0]            sync2_q, sync2_d;
   logic [DIV_W-1:0]           pre_q, pre_d;
   logic                       tick;
   logic [N_SW-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [N_SW-1:0]            level_q, level_d;
   logic [N_SW-1:0]            pulse_q, pulse_d;
   logic                       valid_q, valid_d;
   logic                       multi_q, multi_d;
   logic [3:0]                 code_q, code_d;

   // Two-stage synchroniser for the asynchronous switch pins.
   always_comb begin
      sync1_d = norm;
      sync2_d = sync1_q;
   end

   // Sample prescaler: tick is high for the last cycle of each SAMPLE_DIV period.
   always_comb begin
      tick  = (pre_q == DIV_LAST);
      pre_d = tick ? '0 : pre_q + DIV_W'(1);
   end

   // Per-switch stability counter; any tick agreeing with the current level restarts it.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (tick) begin
         for (int i = 0; i < N_SW; i++) begin
            if (sync2_q[i] == level_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               level_d[i] = ~level_q[i];
               cnt_d[i]   = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Press strobes and key encoding, registered alongside the level so they line up.
   always_comb begin
      pulse_d = level_d & ~level_q;
      valid_d = |pulse_d;
      multi_d = |(pulse_d & (pulse_d - N_SW'(1)));
      code_d  = code_q;
      if (valid_d) begin
         for (int i = N_SW - 1; i >= 0; i--) begin
            if (pulse_d[i]) begin
               code_d = 4'(i);
            end
         end
      end
   end

   // State registers; everything returns to the released/idle state on reset.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         sync1_q <= '0;
         sync2_q <= '0;
         pre_q   <= '0;
         cnt_q   <= '0;
         level_q <= '0;
         pulse_q <= '0;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
         code_q  <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
         valid_q <= valid_d;
         multi_q <= multi_d;
         code_q  <= code_d;
      end
   end

   assign PSW_LEVEL = level_q;
   assign PSW_PULSE = pulse_q;
   assign KEY_VALID = valid_q;
   assign KEY_CODE  = code_q;
   assign KEY_MULTI = multi_q;

endmodule

// File: tb/tb_psw_debounce.sv
// tb/tb_psw_debounce.sv - randomized and directed bench for psw_debounce against a window model
module tb_psw_debounce;
   localparam int N    = 14;
   localparam int SDIV = 4;
   localparam int SCNT = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] psw = '0;
   logic [N-1:0] psw_inv;
   logic [N-1:0] level0, pulse0, level1, pulse1;
   logic         valid0, multi0, valid1, multi1;
   logic [3:0]   code0, code1;

   assign psw_inv = ~psw;

   psw_debounce #(.N_SW(N), .SAMPLE_DIV(SDIV), .STABLE_CNT(SCNT), .ACTIVE_LOW(1'b0)) dut0 (
      .CLK(clk), .RST_X(rst_n), .PSW(psw),
      .PSW_LEVEL(level0), .PSW_PULSE(pulse0), .KEY_VALID(valid0), .KEY_CODE(code0), .KEY_MULTI(multi0));

   psw_debounce #(.N_SW(N), .SAMPLE_DIV(SDIV), .STABLE_CNT(SCNT), .ACTIVE_LOW(1'b1)) dut1 (
      .CLK(clk), .RST_X(rst_n), .PSW(psw_inv),
      .PSW_LEVEL(level1), .PSW_PULSE(pulse1), .KEY_VALID(valid1), .KEY_CODE(code1), .KEY_MULTI(multi1));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   // reference model: sample history of pins, tick-sample window per switch
   int           k;
   logic [N-1:0] hist[$];
   logic [N-1:0] thist[$];
   logic [N-1:0] m_level, m_pulse;
   logic         m_valid, m_multi;
   logic [3:0]   m_code;

   // observation accumulators for directed scenarios
   int           vcnt, mcnt;
   logic [N-1:0] por;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] lowest(input logic [N-1:0] v);
      int i = 0;
      while (i < N && !v[i]) i++;
      return 4'(i);
   endfunction

   task automatic model_reset();
      k = 0;
      hist.delete();
      thist.delete();
      m_level = '0;
      m_pulse = '0;
      m_valid = 1'b0;
      m_multi = 1'b0;
      m_code  = '0;
   endtask

   task automatic model_edge();
      logic [N-1:0] s, nl;
      bit differs;
      k++;
      hist.push_back(psw);
      s = (hist.size() >= 3) ? hist[hist.size()-3] : '0;
      if (hist.size() > 3) void'(hist.pop_front());
      m_pulse = '0;
      m_valid = 1'b0;
      m_multi = 1'b0;
      if (k % SDIV == 0) begin
         thist.push_back(s);
         if (thist.size() > SCNT) void'(thist.pop_front());
         nl = m_level;
         if (thist.size() == SCNT) begin
            for (int i = 0; i < N; i++) begin
               differs = 1'b1;
               foreach (thist[j]) if (thist[j][i] == m_level[i]) differs = 1'b0;
               if (differs) nl[i] = ~m_level[i];
            end
         end
         m_pulse = nl & ~m_level;
         m_level = nl;
         if (m_pulse != '0) begin
            m_valid = 1'b1;
            m_multi = ($countones(m_pulse) > 1);
            m_code  = lowest(m_pulse);
         end
      end
   endtask

   task automatic compare_all();
      check("lvl0", 64'(level0), 64'(m_level));
      check("pls0", 64'(pulse0), 64'(m_pulse));
      check("vld0", 64'(valid0), 64'(m_valid));
      check("code0", 64'(code0), 64'(m_code));
      check("mul0", 64'(multi0), 64'(m_multi));
      check("lvl1", 64'(level1), 64'(m_level));
      check("pls1", 64'(pulse1), 64'(m_pulse));
      check("vld1", 64'(valid1), 64'(m_valid));
      check("code1", 64'(code1), 64'(m_code));
      check("mul1", 64'(multi1), 64'(m_multi));
      check("tick", 64'(dut0.tick), 64'(rst_n && ((k + 1) % SDIV == 0)));
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge();
      @(negedge clk);
      compare_all();
      if (valid0) begin
         vcnt++;
         por = por | pulse0;
      end
      if (multi0) mcnt++;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic clear_acc();
      vcnt = 0;
      mcnt = 0;
      por  = '0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_dut0"}, 64'({level0, pulse0, valid0, code0, multi0}), 64'(0));
      check({tag, "_dut1"}, 64'({level1, pulse1, valid1, code1, multi1}), 64'(0));
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      model_reset();
      run(2);
      rst_n = 1'b1;
   endtask

   initial begin
      int  b;
      bit  reached;
      model_reset();
      clear_acc();
      repeat (3) @(negedge clk);
      check_zero("rst_hold");
      rst_n = 1'b1;

      // idle after reset
      run(100);
      check("t1_vcnt", 64'(vcnt), 64'(0));
      check("t1_level", 64'(level0 | level1), 64'(0));

      // clean press of switch 5
      clear_acc();
      psw[5] = 1'b1;
      run(40);
      check("t2_vcnt", 64'(vcnt), 64'(1));
      check("t2_por", 64'(por), 64'(14'h0020));
      check("t2_code", 64'(code0), 64'(5));
      check("t2_level", 64'(level0[5]), 64'(1));

      // release of switch 5
      clear_acc();
      psw[5] = 1'b0;
      run(40);
      check("t5_vcnt", 64'(vcnt), 64'(0));
      check("t5_level", 64'(level0[5]), 64'(0));
      check("t5_code", 64'(code0), 64'(5));
      check("t5_code1", 64'(code1), 64'(5));

      // switch 2 bounces across ticks, then holds
      clear_acc();
      psw[2] = 1'b1;
      run(SDIV);
      psw[2] = 1'b0;
      run(SDIV);
      psw[2] = 1'b1;
      run(40);
      check("t3_vcnt", 64'(vcnt), 64'(1));
      check("t3_por", 64'(por), 64'(14'h0004));
      check("t3_code", 64'(code0), 64'(2));

      // simultaneous presses of 3 and 9
      clear_acc();
      psw[3] = 1'b1;
      psw[9] = 1'b1;
      run(40);
      check("t4_vcnt", 64'(vcnt), 64'(1));
      check("t4_por", 64'(por), 64'(14'h0208));
      check("t4_mcnt", 64'(mcnt), 64'(1));
      check("t4_code", 64'(code0), 64'(3));
      check("t4_code1", 64'(code1), 64'(3));

      // reset while switch 7 is mid-debounce
      clear_acc();
      psw = 14'h0080;
      reached = 1'b0;
      for (int c = 0; c < 60 && !reached; c++) begin
         step();
         if (thist.size() >= 2 && thist[thist.size()-1][7] && thist[thist.size()-2][7] && !m_level[7])
            reached = 1'b1;
      end
      check("t6_reach_cnt2", 64'(reached), 64'(1));
      check("t6_pre_level", 64'(level0), 64'(14'h020C));
      do_reset();
      clear_acc();
      run(40);
      check("t6_vcnt", 64'(vcnt), 64'(1));
      check("t6_por", 64'(por), 64'(14'h0080));
      check("t6_code", 64'(code0), 64'(7));
      check("t6_code1", 64'(code1), 64'(7));
      check("t6_level", 64'(level0), 64'(14'h0080));

      // randomized toggles, bursts and occasional resets
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            b = $urandom_range(0, N - 1);
            psw[b] = ~psw[b];
         end
         if ($urandom_range(0, 199) == 0) psw = N'($urandom);
         if ($urandom_range(0, 799) == 0) do_reset();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
